// File: rtl/mul_hilo_unit.sv
// HI/LO multiply sequencer: latches operands for an external combinational multiplier,
// waits SETTLE_CYCLES clocks, captures the product. Optional macro MUL_UNSIGNED_EN adds port uns.
//
// state  | meaning
// IDLE   | ready; accepts start or direct hi_wr/lo_wr writes
// WAIT   | multiplier settling; cnt counts down to capture
// DONE   | one-cycle completion pulse; direct writes allowed
module mul_hilo_unit #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
`ifdef MUL_UNSIGNED_EN
    input  logic        uns,
`endif
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [63:0] mul_z,
    input  logic        hi_wr,
    input  logic        lo_wr,
    input  logic [31:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] mul_a_q, mul_a_d;
    logic [31:0] mul_b_q, mul_b_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] hi_cap;

`ifdef MUL_UNSIGNED_EN
    logic        uns_q, uns_d;

    // Converts the signed high word to the unsigned one: add back b*2^32 / a*2^32
    // for each operand whose sign bit was treated as negative.
    always_comb begin
        hi_cap = mul_z[63:32];
        if (uns_q) begin
            hi_cap = mul_z[63:32] + (mul_a_q[31] ? mul_b_q : 32'd0)
                                  + (mul_b_q[31] ? mul_a_q : 32'd0);
        end
    end
`else
    always_comb hi_cap = mul_z[63:32];
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
`ifdef MUL_UNSIGNED_EN
        uns_d   = uns_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mul_a_d = a;
                    mul_b_d = b;
`ifdef MUL_UNSIGNED_EN
                    uns_d   = uns;
`endif
                    cnt_d   = 4'(SETTLE_CYCLES);
                    state_d = S_WAIT;
                end else begin
                    if (hi_wr) hi_d = wr_data;
                    if (lo_wr) lo_d = wr_data;
                end
            end
            S_WAIT: begin
                // <= 1 also covers an out-of-range SETTLE_CYCLES of 0
                if (cnt_q <= 4'd1) begin
                    hi_d    = hi_cap;
                    lo_d    = mul_z[31:0];
                    cnt_d   = 4'd0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE: begin
                if (hi_wr) hi_d = wr_data;
                if (lo_wr) lo_d = wr_data;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            mul_a_q <= 32'd0;
            mul_b_q <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
`ifdef MUL_UNSIGNED_EN
            uns_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mul_a_q <= mul_a_d;
            mul_b_q <= mul_b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
`ifdef MUL_UNSIGNED_EN
            uns_q   <= uns_d;
`endif
        end
    end

    assign mul_a  = mul_a_q;
    assign mul_b  = mul_b_q;
    assign busy   = (state_q == S_WAIT);
    assign done   = (state_q == S_DONE);
    assign hi_out = hi_q;
    assign lo_out = lo_q;

endmodule

// File: doc/mul_hilo_unit.md
MUL_HILO_UNIT -- requirements
Module: mul_hilo_unit

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, number of clocks allowed for the combinational multiplier to settle (legal 1..15).
REQ-002 SHALL have port clock  input  1  rising-edge clock for all state.
REQ-003 SHALL have port clear  input  1  reset; one clock and synchronous active-high reset.
REQ-004 SHALL have port start  input  1  request a multiply of a and b; sampled only in IDLE.
REQ-005 SHALL have ports a, b  input  32 each  signed operands.
REQ-006 SHALL have port mul_a, mul_b  output  32 each  registered operands driven to the multiplier.
REQ-007 SHALL have port mul_z  input  64  product returned by the multiplier.
REQ-008 SHALL have ports hi_wr, lo_wr  input  1 each  direct write strobes (MTHI/MTLO).
REQ-009 SHALL have port wr_data  input  32  data for hi_wr/lo_wr.
REQ-010 SHALL have ports busy, done  output  1 each  operation in flight / one-cycle completion pulse.
REQ-011 SHALL have ports hi_out, lo_out  output  32 each  HI and LO register contents.

Function
REQ-012 SHALL implement states IDLE, WAIT, DONE; a 4-bit down-counter cnt is used in WAIT.
REQ-013 IDLE with start=1 at edge N SHALL latch a->mul_a, b->mul_b, load cnt=SETTLE_CYCLES, go to WAIT.
REQ-014 WAIT SHALL decrement cnt each edge; on the edge where cnt==1 it SHALL capture mul_z[63:32]->HI, mul_z[31:0]->LO and go to DONE.
REQ-015 DONE SHALL last exactly one cycle, done=1, then return to IDLE unconditionally.
REQ-016 Latency: start sampled at edge N -> done=1 during the cycle after edge N+SETTLE_CYCLES; HI/LO valid in that same cycle.
REQ-017 busy SHALL be 1 in WAIT only; done SHALL be 1 in DONE only; never both.
REQ-018 start in WAIT or DONE SHALL be ignored (not queued).
REQ-019 mul_a/mul_b SHALL hold their values from latch until the next accepted start.
REQ-020 hi_wr/lo_wr SHALL update HI/LO from wr_data in IDLE and DONE; ignored in WAIT.
REQ-021 hi_wr and lo_wr together SHALL write both registers with wr_data.
REQ-022 start and hi_wr/lo_wr in the same IDLE cycle: start SHALL win, write dropped.
REQ-023 hi_out/lo_out SHALL be direct register outputs, no combinational path from inputs.

Reset
REQ-024 clear=1 at an edge SHALL force IDLE, cnt=0, HI=LO=0, mul_a=mul_b=0, busy=0, done=0, overriding all other inputs.
REQ-025 clear during WAIT SHALL abort the operation; no capture, no done pulse.

Configuration
REQ-026 Macro MUL_UNSIGNED_EN SHALL, when defined, add input port uns (1 bit) sampled with start and held with the operands.
REQ-027 With MUL_UNSIGNED_EN and uns=1, capture SHALL add (mul_a[31]?mul_b:0)+(mul_b[31]?mul_a:0) modulo 2^32 to mul_z[63:32] before writing HI; LO unchanged.
REQ-028 Without MUL_UNSIGNED_EN, port uns SHALL not exist and all multiplies SHALL be signed.

Verification
REQ-029 SETTLE_CYCLES=2, a=7, b=-3, start at edge 0 -> busy cycles 1-2, done cycle 3, HI=FFFFFFFF, LO=FFFFFFEB.
REQ-030 a=80000000, b=80000000 -> HI=40000000, LO=00000000; a=-1, b=-1 -> HI=0, LO=1.
REQ-031 start held high through WAIT and DONE -> exactly one done pulse per IDLE acceptance, second operation starts after return to IDLE.
REQ-032 clear asserted at second WAIT edge -> IDLE next cycle, HI/LO=0, no done pulse.
REQ-033 hi_wr with wr_data=12345678 in IDLE -> hi_out=12345678; same write during WAIT -> no change.
REQ-034 With MUL_UNSIGNED_EN, uns=1, a=b=FFFFFFFF -> HI=FFFFFFFE, LO=00000001; uns=0 same operands -> HI=0, LO=1.
